// File: rtl/pe_tile_loader.sv
// pe_tile_loader: fetches one weight tile followed by one data tile from the
// shared on-chip buffer through a granted, fixed one-cycle-latency read port.
// Each buffer word is split into 4-bit lanes and stored into row-major PE
// arrays. load_en flags the completed weight tile. tile_valid holds the
// completed pair of tiles until the consumer acknowledges it.
module pe_tile_loader #(
  parameter int ARRAY_SIZE         = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int NUM_COMPUTE_LANES  = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
  parameter int ADDR_WIDTH         = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         weight_base_addr,
  input  logic [ADDR_WIDTH-1:0]         data_base_addr,
  output logic                          buf_rd_en,
  output logic [ADDR_WIDTH-1:0]         buf_rd_addr,
  input  logic                          buf_rd_gnt,
  input  logic [BUFFER_WORD_SIZE-1:0]   buf_rd_data,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] weights_in,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] datas_arr,
  output logic                          load_en,
  output logic                          tile_valid,
  input  logic                          tile_ack,
  output logic                          busy
);

  localparam int NUM_ELEMS = ARRAY_SIZE * ARRAY_SIZE;
  // Buffer words per matrix; the fetch covers two matrices back to back.
  localparam int WORDS     = NUM_ELEMS / NUM_COMPUTE_LANES;
  localparam int TOTAL     = 2 * WORDS;
  localparam int CNT_W     = $clog2(TOTAL);

  localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_WEIGHT = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] WORDS_CNT   = CNT_W'(WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]            state_reg;
  logic [CNT_W-1:0]      issue_cnt_reg;
  logic [CNT_W-1:0]      capture_cnt_reg;
  logic [CNT_W-1:0]      issue_next;
  logic                  pending_reg;
  logic                  load_en_reg;
  logic [ADDR_WIDTH-1:0] weight_base_reg;
  logic [ADDR_WIDTH-1:0] data_base_reg;
  logic [ADDR_WIDTH-1:0] rd_addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  accept;
  logic                  fetch_start;
  logic                  last_capture;

  // A read is only issued in FETCH; grant low freezes issue progress.
  assign accept       = (state_reg == ST_FETCH) && buf_rd_gnt;
  assign fetch_start  = (state_reg == ST_IDLE) && start;
  assign last_capture = pending_reg && (capture_cnt_reg == LAST_WORD);
  assign issue_next   = issue_cnt_reg + CNT_W'(1);

  assign buf_rd_en   = (state_reg == ST_FETCH);
  assign buf_rd_addr = rd_addr_reg;
  assign load_en     = load_en_reg;
  assign tile_valid  = (state_reg == ST_HOLD);
  assign busy        = (state_reg != ST_IDLE);

  // Address of the word following the one just accepted: weights first, then
  // data, each offset from its latched base and wrapping at the address width.
  always_comb begin
    addr_next = rd_addr_reg;
    if (issue_next < WORDS_CNT) begin
      addr_next = weight_base_reg + ADDR_WIDTH'(issue_next);
    end else begin
      addr_next = data_base_reg + ADDR_WIDTH'(issue_next - WORDS_CNT);
    end
  end

  // Control FSM, issue counter and the registered read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      issue_cnt_reg   <= '0;
      weight_base_reg <= '0;
      data_base_reg   <= '0;
      rd_addr_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg       <= ST_FETCH;
            issue_cnt_reg   <= '0;
            weight_base_reg <= weight_base_addr;
            data_base_reg   <= data_base_addr;
            rd_addr_reg     <= weight_base_addr;
          end
        end
        ST_FETCH: begin
          if (buf_rd_gnt) begin
            issue_cnt_reg <= issue_next;
            if (issue_cnt_reg == LAST_WORD) begin
              // Leave the address on the final word; nothing more is issued.
              state_reg <= ST_WAIT;
            end else begin
              rd_addr_reg <= addr_next;
            end
          end
        end
        ST_WAIT: begin
          if (last_capture) begin
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tile_ack) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Return-data tracking: pending marks the cycle the accepted word arrives,
  // capture counter walks the words, load_en fires after the last weight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg     <= 1'b0;
      capture_cnt_reg <= '0;
      load_en_reg     <= 1'b0;
    end else begin
      pending_reg <= accept;
      load_en_reg <= pending_reg && (capture_cnt_reg == LAST_WEIGHT);
      if (fetch_start) begin
        capture_cnt_reg <= '0;
      end else if (pending_reg) begin
        capture_cnt_reg <= capture_cnt_reg + CNT_W'(1);
      end
    end
  end

  // One storage word per buffer word of each matrix. Lane j of matrix word w
  // lands on element NUM_COMPUTE_LANES*w + j, which the packed slice gives.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [BUFFER_WORD_SIZE-1:0] weight_word_reg;
      logic [BUFFER_WORD_SIZE-1:0] data_word_reg;

      // Weight word gi is written only when its capture slot comes up.
      always_ff @(posedge clk) begin
        if (rst) begin
          weight_word_reg <= '0;
        end else if (pending_reg && (capture_cnt_reg == CNT_W'(gi))) begin
          weight_word_reg <= buf_rd_data;
        end
      end

      // Data word gi follows the full weight matrix in capture order.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_word_reg <= '0;
        end else if (pending_reg && (capture_cnt_reg == CNT_W'(gi + WORDS))) begin
          data_word_reg <= buf_rd_data;
        end
      end

      assign weights_in[NUM_COMPUTE_LANES*gi +: NUM_COMPUTE_LANES] = weight_word_reg;
      assign datas_arr[NUM_COMPUTE_LANES*gi +: NUM_COMPUTE_LANES]  = data_word_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pe_tile_loader.sv
// Bench for pe_tile_loader: a table of fetch scenarios plus hand-written
// reset sequences. Issued addresses are scored against a queue of expected
// addresses; tiles are compared element by element against bench-built values.
module tb_pe_tile_loader;

  localparam int AW    = 10;
  localparam int NE    = 64;
  localparam int WORDS = 16;

  typedef struct packed {
    logic [AW-1:0] wbase;
    logic [AW-1:0] dbase;
    bit            spec_pat;
    bit            stall;
    int            load_off;
    int            valid_off;
    int            hold;
    bit            start_in_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, buf_rd_en, buf_rd_gnt, load_en, tile_valid, tile_ack, busy;
  logic [AW-1:0] weight_base_addr, data_base_addr, buf_rd_addr;
  logic [15:0]   buf_rd_data;
  logic [NE-1:0][3:0] weights_in, datas_arr;

  logic [15:0]   mem [1024];
  logic [3:0]    exp_w [NE];
  logic [3:0]    exp_d [NE];
  logic [AW-1:0] addr_q [$];

  int vec_cnt  = 0;
  int fail_cnt = 0;
  int cyc      = 0;
  int load_cnt = 0;
  int load_cyc = -1;
  int tv_cyc   = -1;
  logic          prev_stalled = 1'b0;
  logic [AW-1:0] prev_addr    = '0;

  always #5 clk = ~clk;

  pe_tile_loader dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .weight_base_addr (weight_base_addr),
    .data_base_addr   (data_base_addr),
    .buf_rd_en        (buf_rd_en),
    .buf_rd_addr      (buf_rd_addr),
    .buf_rd_gnt       (buf_rd_gnt),
    .buf_rd_data      (buf_rd_data),
    .weights_in       (weights_in),
    .datas_arr        (datas_arr),
    .load_en          (load_en),
    .tile_valid       (tile_valid),
    .tile_ack         (tile_ack),
    .busy             (busy)
  );

  // Buffer model: accepted read returns its word one cycle later, garbage otherwise.
  always @(posedge clk) begin
    buf_rd_data <= (buf_rd_en && buf_rd_gnt) ? mem[buf_rd_addr] : 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: monitor at the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (buf_rd_en && prev_stalled) begin
      check("addr_hold_in_stall", 32'(buf_rd_addr), 32'(prev_addr));
    end
    prev_stalled = buf_rd_en && !buf_rd_gnt;
    prev_addr    = buf_rd_addr;
    if (buf_rd_en && buf_rd_gnt) begin
      if (addr_q.size() == 0) begin
        vec_cnt++;
        fail_cnt++;
        $display("FAIL extra_read: got addr %0d expected no read (cycle %0d)", buf_rd_addr, cyc);
      end else begin
        check("rd_addr", 32'(buf_rd_addr), 32'(addr_q.pop_front()));
      end
    end
    if (load_en) begin
      load_cnt++;
      load_cyc = cyc;
    end
    if (tile_valid && tv_cyc < 0) tv_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic gnt_at(input int off, input bit stall);
    return !(stall && ((off >= 6 && off <= 10) || (off >= 26 && off <= 28)));
  endfunction

  // Place both matrices in the buffer, build the expected tiles and addresses.
  task automatic fill_tile(input logic [AW-1:0] wb, input logic [AW-1:0] db, input bit spec);
    logic [15:0]   word;
    logic [AW-1:0] a;
    logic [3:0]    kk;
    for (int k = 0; k < WORDS; k++) begin
      kk   = 4'(k);
      word = spec ? {4{kk}} : 16'($urandom);
      a    = wb + AW'(k);
      mem[a] = word;
      for (int j = 0; j < 4; j++) exp_w[4*k+j] = spec ? kk : word[4*j +: 4];
      word = spec ? 16'h8F01 : 16'($urandom);
      a    = db + AW'(k);
      mem[a] = word;
      if (spec) begin
        exp_d[4*k+0] = 4'h1;
        exp_d[4*k+1] = 4'h0;
        exp_d[4*k+2] = 4'hF;
        exp_d[4*k+3] = 4'h8;
      end else begin
        for (int j = 0; j < 4; j++) exp_d[4*k+j] = word[4*j +: 4];
      end
    end
    addr_q.delete();
    for (int k = 0; k < WORDS; k++) addr_q.push_back(wb + AW'(k));
    for (int k = 0; k < WORDS; k++) addr_q.push_back(db + AW'(k));
  endtask

  task automatic check_tile();
    for (int e = 0; e < NE; e++) begin
      check($sformatf("weights_in[%0d]", e), 32'(weights_in[e]), 32'(exp_w[e]));
      check($sformatf("datas_arr[%0d]", e), 32'(datas_arr[e]), 32'(exp_d[e]));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 32'(buf_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(buf_rd_addr), 32'd0);
    check({tag, "_load_en"}, 32'(load_en), 32'd0);
    check({tag, "_tile_valid"}, 32'(tile_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    for (int e = 0; e < NE; e++) begin
      check($sformatf("%s_w[%0d]", tag, e), 32'(weights_in[e]), 32'd0);
      check($sformatf("%s_d[%0d]", tag, e), 32'(datas_arr[e]), 32'd0);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int t0;
    fill_tile(v.wbase, v.dbase, v.spec_pat);
    load_cnt = 0;
    load_cyc = -1;
    tv_cyc   = -1;
    weight_base_addr = v.wbase;
    data_base_addr   = v.dbase;
    buf_rd_gnt = 1'b1;
    start      = 1'b1;
    t0 = cyc;
    cycle();
    start = 1'b0;
    // Bases must already be latched; scramble the inputs.
    weight_base_addr = ~v.wbase;
    data_base_addr   = ~v.dbase;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int n = 0; n < 200 && tv_cyc < 0; n++) begin
      buf_rd_gnt = gnt_at(cyc - t0, v.stall);
      tile_ack   = (cyc - t0 == 12);
      cycle();
    end
    buf_rd_gnt = 1'b1;
    tile_ack   = 1'b0;
    if (tv_cyc < 0) begin
      vec_cnt++;
      fail_cnt++;
      $display("FAIL tile_valid_timeout: got no tile_valid expected one within 200 cycles");
    end
    check("load_en_offset", 32'(load_cyc - t0), 32'(v.load_off));
    check("tile_valid_offset", 32'(tv_cyc - t0), 32'(v.valid_off));
    check("reads_outstanding", 32'(addr_q.size()), 32'd0);
    check_tile();
    for (int i = 0; i < v.hold; i++) begin
      if (v.start_in_hold && i == v.hold / 2) begin
        start = 1'b1;
        weight_base_addr = 10'd7;
        data_base_addr   = 10'd9;
      end
      cycle();
      start = 1'b0;
      check("tile_valid_in_hold", 32'(tile_valid), 32'd1);
      check("rd_en_in_hold", 32'(buf_rd_en), 32'd0);
    end
    check_tile();
    tile_ack = 1'b1;
    cycle();
    tile_ack = 1'b0;
    check("tile_valid_after_ack", 32'(tile_valid), 32'd0);
    check("busy_after_ack", 32'(busy), 32'd0);
    check("load_en_pulses", 32'(load_cnt), 32'd1);
    $display("vector %0d: wbase=%0d dbase=%0d stall=%0d load_en@T+%0d tile_valid@T+%0d",
             idx, v.wbase, v.dbase, v.stall, load_cyc - t0, tv_cyc - t0);
  endtask

  initial begin
    vec_t vecs[5];
    int   t0;
    rst = 1'b1;
    start = 1'b0;
    tile_ack = 1'b0;
    buf_rd_gnt = 1'b1;
    weight_base_addr = '0;
    data_base_addr   = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 16'hBEEF;

    //          wbase     dbase     spec  stall load valid hold start_in_hold
    vecs[0] = '{10'd0,    10'd512,  1'b1, 1'b0, 18,  34,   2,   1'b0};
    vecs[1] = '{10'd64,   10'd700,  1'b1, 1'b1, 23,  42,   2,   1'b0};
    vecs[2] = '{10'd1020, 10'd300,  1'b0, 1'b0, 18,  34,   2,   1'b0};
    vecs[3] = '{10'd40,   10'd900,  1'b0, 1'b0, 18,  34,   20,  1'b1};
    vecs[4] = '{10'd500,  10'd1015, 1'b0, 1'b1, 23,  42,   3,   1'b0};

    repeat (3) cycle();
    rst = 1'b0;
    check_zero("reset");
    $display("reset: outputs and arrays checked");

    for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

    // Reset while capture count is 9 and a read is being accepted.
    fill_tile(10'd100, 10'd600, 1'b0);
    weight_base_addr = 10'd100;
    data_base_addr   = 10'd600;
    start = 1'b1;
    t0 = cyc;
    cycle();
    start = 1'b0;
    repeat (10) cycle();
    check("pre_reset_word8", 32'(weights_in[32]), 32'(exp_w[32]));
    check("pre_reset_rd_en", 32'(buf_rd_en), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_zero("midrst");
    addr_q.delete();
    cycle();
    check_zero("no_late_write");
    $display("mid-fetch reset: asserted at T+%0d, state cleared", cyc - t0 - 2);

    run_vec(5, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pe_tile_loader.md
# pe_tile_loader

Upstream feeder for `pe_controller`. It fetches one weight tile and one data tile from the unified on-chip buffer over a granted, fixed-latency read port. Each 16-bit buffer word is unpacked into four 4-bit lanes. The loader assembles the `ARRAY_SIZE×ARRAY_SIZE` row-major arrays `weights_in` and `datas_arr`, pulses `load_en` once the weights are complete, and holds the finished tile valid until the consumer acknowledges it.

## Interface
- `ARRAY_SIZE`, 8, PE array dimension; tile holds `ARRAY_SIZE*ARRAY_SIZE` elements.
- `COMPUTE_DATA_WIDTH`, 4, signed element width.
- `BUFFER_WORD_SIZE`, 16, buffer read word width.
- `NUM_COMPUTE_LANES`, `BUFFER_WORD_SIZE/COMPUTE_DATA_WIDTH`, elements per word.
- `ADDR_WIDTH`, 10, buffer word-address width.
- `clk`, in, 1, clock.
- `rst`, in, 1, reset; synchronous, active-high.
- `start`, in, 1, begin a tile fetch; sampled only in IDLE.
- `weight_base_addr`, in, `ADDR_WIDTH`, first weight word; captured with `start`.
- `data_base_addr`, in, `ADDR_WIDTH`, first data word; captured with `start`.
- `buf_rd_en`, out, 1, read request.
- `buf_rd_addr`, out, `ADDR_WIDTH`, read word address.
- `buf_rd_gnt`, in, 1, arbiter grant; a read is accepted when `buf_rd_en && buf_rd_gnt`.
- `buf_rd_data`, in, `BUFFER_WORD_SIZE`, read data, valid exactly 1 cycle after acceptance.
- `weights_in`, out, `COMPUTE_DATA_WIDTH` × `ARRAY_SIZE*ARRAY_SIZE`, weight tile.
- `datas_arr`, out, `COMPUTE_DATA_WIDTH` × `ARRAY_SIZE*ARRAY_SIZE`, data tile.
- `load_en`, out, 1, one-cycle pulse: `weights_in` complete.
- `tile_valid`, out, 1, both arrays complete and stable.
- `tile_ack`, in, 1, consumer releases tile; honored only while `tile_valid`.
- `busy`, out, 1, high in every state except IDLE.

## Operation
- `W = ARRAY_SIZE*ARRAY_SIZE/NUM_COMPUTE_LANES` words per matrix (16 at default sizes). Total fetch is `2W` words, weights first, then data.
- Issue address: word `k < W` reads `weight_base_addr + k`; word `k ≥ W` reads `data_base_addr + (k−W)`. Addition wraps modulo `2^ADDR_WIDTH`.
- Unpack: matrix word `w`, lane `j` (bits `[4j+3:4j]`) is written to element `NUM_COMPUTE_LANES*w + j`. Element `e` is row `e/ARRAY_SIZE`, column `e%ARRAY_SIZE` (row-major).
- There is a separate issue counter and capture counter, each `0..2W−1`. A one-cycle `pending` flag marks an accepted read. Capture happens only when `pending` is set.
- FSM states:
  - IDLE: `start` → FETCH. Clear both counters and latch both base addresses.
  - FETCH: `buf_rd_en=1`. The issue counter increments on each accepted read. When the read with issue count `2W−1` is accepted → WAIT.
  - WAIT: `buf_rd_en=0`. Remain here until capture count `2W−1` is written → HOLD.
  - HOLD: `tile_valid=1`. On `tile_ack` → IDLE.
- `load_en` pulses for exactly one cycle, in the cycle after weight word `W−1` is captured. The pulse is independent of FSM state, so it normally occurs while data is still being fetched.
- Array registers change only at capture edges. They are otherwise stable, including across HOLD and IDLE, until the next fetch overwrites them.
- When `buf_rd_gnt` is low, `buf_rd_en` and `buf_rd_addr` hold and nothing advances. Stalls may occur on any cycle.
- `start` outside IDLE is ignored. `tile_ack` outside HOLD is ignored.

## Timing
- Reset values: `buf_rd_en=0`, `buf_rd_addr=0`, `load_en=0`, `tile_valid=0`, `busy=0`, all array elements 0, counters 0, `pending=0`, state IDLE.
- Let `start` be sampled at the end of cycle T, with grant held high:
  - Reads are accepted in cycles T+1..T+2W.
  - Weight word `W−1` is captured at the end of T+W+1. `load_en` is high in T+W+2.
  - The last data word is captured at the end of T+2W+1. `tile_valid` is high from T+2W+2.
  - Defaults give `load_en` at T+18 and `tile_valid` at T+34. Each stalled cycle adds one.
- `tile_ack` in cycle H: `tile_valid` and `busy` go low in H+1. A new `start` is accepted in H+1 at the earliest.
- `rst` mid-operation: all state returns to reset values at the next edge. The return data of a read accepted in the reset cycle is discarded because `pending` is cleared.

## Test plan
- Basic fetch, grant tied high: weight word k = `{4{k[3:0]}}`, data word k = `16'h8F01`. Required: every `weights_in[4k+j] == k` (as signed 4-bit); every `datas_arr[4j+0]=1`, `[4j+1]=0`, `[4j+2]=−1`, `[4j+3]=−8`; `load_en` is a single pulse at T+18; `tile_valid` from T+34.
- Grant stall: deassert `buf_rd_gnt` for 5 cycles mid-weights and 3 cycles mid-data. Required: `buf_rd_addr` holds through each stall, there are no duplicate or skipped addresses, `load_en` moves to T+23, `tile_valid` to T+42, and array contents match the first test.
- Address wrap: `weight_base_addr=1020`, `ADDR_WIDTH=10`. Required: issued addresses are 1020..1023 then 0..11; `data_base_addr` sequence is unaffected.
- Handshake: hold `tile_ack=0` for 20 cycles in HOLD, pulse `start` during HOLD, then assert ack. Required: tile stays valid and unchanged, the `start` is ignored, `tile_valid=0` in the cycle after ack, and a following `start` fetches normally.
- Reset mid-fetch: assert `rst` at capture count 9. Required: all outputs and arrays are 0 on the next cycle; the in-flight return is not written; a fresh `start` completes a correct tile.
